// File: rtl/uart_pkg.sv
// Shared UART constants used by uart_tx, uart_rx and their FIFOs.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_TX_FIFO_DEPTH = 16;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DW storage with a synchronous write port and an asynchronous read port.
// Contents are not reset; validity is tracked by the owning FIFO's pointers.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through transmit FIFO feeding uart_tx; level, overflow and synchronous flush.
// Optional low-level watermark interrupt enabled by defining UART_TX_FIFO_WMARK_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_TX_FIFO_DEPTH,
  parameter int DW    = UART_DATA_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          flush,
  output logic          tx_valid,
  output logic [DW-1:0] tx_data,
  input  logic          tx_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
`ifdef UART_TX_FIFO_WMARK_EN
  input  logic [AW:0]   cfg_wmark,
  output logic          irq_wmark,
`endif
  output logic          overflow
);

  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [DW-1:0] w_rd_data;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_push = wr_valid && !w_full && !flush;
  assign w_pop  = tx_ready && !w_empty && !flush;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (wr_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_data)
  );

  // Head is forced to zero when empty so stale RAM never reaches uart_tx.
  assign tx_data  = w_empty ? '0 : w_rd_data;
  assign tx_valid = !w_empty;
  assign wr_ready = !w_full;
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = r_wr_ptr - r_rd_ptr;
  assign overflow = r_overflow;

`ifdef UART_TX_FIFO_WMARK_EN
  logic r_irq_wmark;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      r_irq_wmark <= 1'b0;
    end else begin
      r_irq_wmark <= (level <= cfg_wmark) && !flush;
    end
  end

  assign irq_wmark = r_irq_wmark;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed vector table, corner sequences, and random traffic vs a queue model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          flush;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef UART_TX_FIFO_WMARK_EN
  logic [AW:0]   cfg_wmark;
  logic          irq_wmark;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
`ifdef UART_TX_FIFO_WMARK_EN
    .cfg_wmark (cfg_wmark),
    .irq_wmark (irq_wmark),
`endif
    .overflow  (overflow)
  );

  typedef struct {
    logic       wv;
    logic [7:0] wd;
    logic       rdy;
    logic       fl;
    int         lvl;
    logic       vld;
    logic [7:0] dat;
    logic       ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [7:0] wd, input logic rdy, input logic fl);
    wr_valid = wv;
    wr_data  = wd;
    tx_ready = rdy;
    flush    = fl;
  endtask

  task automatic check_state(input string tag, input int lvl, input logic [7:0] dat, input logic ovf);
    chk({tag, ".level"},    32'(level),    32'(lvl));
    chk({tag, ".tx_valid"}, 32'(tx_valid), 32'(lvl != 0));
    chk({tag, ".tx_data"},  32'(tx_data),  32'(dat));
    chk({tag, ".full"},     32'(full),     32'(lvl == DEPTH));
    chk({tag, ".empty"},    32'(empty),    32'(lvl == 0));
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(lvl != DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // Reference model: byte queue plus sticky overflow, advanced once per clock.
  byte unsigned q[$];
  logic         m_ovf;

  initial begin
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 8'hA5, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0};
    tbl[3] = '{1'b1, 8'h77, 1'b1, 1'b0, 1, 1'b1, 8'h77, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 8'h11, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 8'h22, 1'b0, 1'b0, 1, 1'b1, 8'h22, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h00, 1'b0};

    rst_b = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_TX_FIFO_WMARK_EN
    cfg_wmark = 5'd4;
`endif
    #30;
    check_state("reset", 0, 8'h00, 1'b0);
`ifdef UART_TX_FIFO_WMARK_EN
    chk("reset.irq_wmark", 32'(irq_wmark), 32'd0);
`endif
    rst_b = 1'b0;
    step();

    foreach (tbl[i]) begin
      drive(tbl[i].wv, tbl[i].wd, tbl[i].rdy, tbl[i].fl);
      step();
      chk($sformatf("vec%0d.level", i),    32'(level),    32'(tbl[i].lvl));
      chk($sformatf("vec%0d.tx_valid", i), 32'(tx_valid), 32'(tbl[i].vld));
      chk($sformatf("vec%0d.tx_data", i),  32'(tx_data),  32'(tbl[i].dat));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Fill while the transmitter stalls.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0);
      step();
    end
    check_state("fill", 16, 8'h00, 1'b0);

    // Write while full with a same-cycle pop: write dropped, overflow set.
    drive(1'b1, 8'hFF, 1'b1, 1'b0);
    step();
    check_state("ovf", 15, 8'h01, 1'b1);

    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain%0d.tx_data", i), 32'(tx_data), 32'(i));
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      step();
    end
    check_state("drained", 0, 8'h00, 1'b1);

    // Flush with a concurrent write clears everything including overflow.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
      step();
    end
    check_state("pre_flush", 5, 8'h40, 1'b1);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    step();
    check_state("flush", 0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    step();
    check_state("post_flush", 0, 8'h00, 1'b0);

    // Asynchronous reset mid-transfer, observed before any clock edge.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    rst_b = 1'b1;
    #1;
    check_state("async_rst", 0, 8'h00, 1'b0);
    #2;
    rst_b = 1'b0;
    step();

    q.delete();
    m_ovf = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      logic       wv, rdy, fl;
      logic [7:0] wd;
      logic       exp_irq;
      bit         fill_phase;
      fill_phase = ((cyc / 200) % 2) == 0;
      wv  = ($urandom_range(0, 99) < (fill_phase ? 80 : 30));
      rdy = ($urandom_range(0, 99) < (fill_phase ? 30 : 80));
      fl  = ($urandom_range(0, 59) == 0);
      wd  = 8'($urandom);
      exp_irq = 1'b0;
`ifdef UART_TX_FIFO_WMARK_EN
      exp_irq = (q.size() <= int'(cfg_wmark)) && !fl;
`endif
      drive(wv, wd, rdy, fl);
      if (fl) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        bit was_full;
        was_full = (q.size() == DEPTH);
        if (rdy && q.size() != 0) void'(q.pop_front());
        if (wv && !was_full) q.push_back(wd);
        if (wv && was_full) m_ovf = 1'b1;
      end
      step();
      check_state($sformatf("rnd%0d", cyc), q.size(), (q.size() != 0) ? q[0] : 8'h00, m_ovf);
`ifdef UART_TX_FIFO_WMARK_EN
      chk($sformatf("rnd%0d.irq_wmark", cyc), 32'(irq_wmark), 32'(exp_irq));
`else
      if (exp_irq) $display("note: unexpected watermark state in model");
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
